dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dm_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port (CPU / debug) arbiter in front of a single-ported data
// memory. Each transaction takes IDLE -> ACCESS -> RESP, three cycles.
// The CPU has priority, but debug is forced through after STARVE_LIMIT
// consecutive CPU wins while it waits.
// Optional feature: define DM_ARB_ALIGN_CHECK_EN to reject word-misaligned
// accesses (no memory strobe, rdata untouched, err pulses with ack).
//
// state  | meaning
// IDLE   | waiting for a request; arbitrates and latches the winner
// ACCESS | memory strobed with the latched address/data (one cycle)
// RESP   | ack (and err) pulse to the granted port
module dm_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_write_data,
  output logic        ctrl_dataMem_Write,
  output logic        ctrl_dataMem2reg,
  input  logic [31:0] dm_read_data,
  output logic        busy,
  output logic        err
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  starve_q, starve_d;
  logic        sel_dbg_q;
  logic        we_q;
  logic        misal_q;
  logic [31:0] dm_addr_q;
  logic [31:0] dm_wdata_q;
  logic        wr_q;
  logic        m2r_q;
  logic        cpu_ack_q;
  logic        dbg_ack_q;
  logic        err_q;
  logic        busy_q;
  logic [31:0] cpu_rdata_q;
  logic [31:0] dbg_rdata_q;

  logic        grant_dbg_d;
  logic        win_we_d;
  logic [31:0] win_addr_d;
  logic [31:0] win_wdata_d;
  logic        win_misal_d;

`ifdef DM_ARB_ALIGN_CHECK_EN
  assign win_misal_d = (win_addr_d[1:0] != 2'b00);
`else
  assign win_misal_d = 1'b0;
`endif

  // Arbitration and starvation-counter next value, used only when leaving IDLE.
  always_comb begin
    grant_dbg_d = dbg_req && (!cpu_req || (starve_q == LIMIT));
    win_we_d    = grant_dbg_d ? dbg_we    : cpu_we;
    win_addr_d  = grant_dbg_d ? dbg_addr  : cpu_addr;
    win_wdata_d = grant_dbg_d ? dbg_wdata : cpu_wdata;
    starve_d    = starve_q;
    if (grant_dbg_d) begin
      starve_d = 4'd0;
    end else if (dbg_req && (starve_q != LIMIT)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Transaction sequencer; all outputs registered so they change only on clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      starve_q    <= 4'd0;
      sel_dbg_q   <= 1'b0;
      we_q        <= 1'b0;
      misal_q     <= 1'b0;
      dm_addr_q   <= 32'd0;
      dm_wdata_q  <= 32'd0;
      wr_q        <= 1'b0;
      m2r_q       <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      cpu_rdata_q <= 32'd0;
      dbg_rdata_q <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cpu_req || dbg_req) begin
            state_q    <= S_ACCESS;
            busy_q     <= 1'b1;
            starve_q   <= starve_d;
            sel_dbg_q  <= grant_dbg_d;
            we_q       <= win_we_d;
            misal_q    <= win_misal_d;
            dm_addr_q  <= win_addr_d;
            dm_wdata_q <= win_wdata_d;
            // A rejected access never strobes the memory.
            wr_q       <= win_we_d & ~win_misal_d;
            m2r_q      <= ~win_we_d & ~win_misal_d;
          end
        end
        S_ACCESS: begin
          state_q    <= S_RESP;
          dm_addr_q  <= 32'd0;
          dm_wdata_q <= 32'd0;
          wr_q       <= 1'b0;
          m2r_q      <= 1'b0;
          if (!we_q && !misal_q) begin
            if (sel_dbg_q) dbg_rdata_q <= dm_read_data;
            else           cpu_rdata_q <= dm_read_data;
          end
          cpu_ack_q  <= ~sel_dbg_q;
          dbg_ack_q  <= sel_dbg_q;
          err_q      <= misal_q;
        end
        S_RESP: begin
          state_q   <= S_IDLE;
          cpu_ack_q <= 1'b0;
          dbg_ack_q <= 1'b0;
          err_q     <= 1'b0;
          busy_q    <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cpu_ack            = cpu_ack_q;
  assign dbg_ack            = dbg_ack_q;
  assign cpu_rdata          = cpu_rdata_q;
  assign dbg_rdata          = dbg_rdata_q;
  assign dm_addr            = dm_addr_q;
  assign dm_write_data      = dm_wdata_q;
  assign ctrl_dataMem_Write = wr_q;
  assign ctrl_dataMem2reg   = m2r_q;
  assign busy               = busy_q;
  assign err                = err_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed vector table, reset-abort and starvation
// sequences, then random two-port traffic against a transaction-level model.
module tb_dm_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dbg_req, dbg_we, dbg_ack;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic [31:0] dm_addr, dm_write_data, dm_read_data;
  logic        ctrl_dataMem_Write, ctrl_dataMem2reg, busy, err;

  logic [31:0] mem [64];
  logic        mem_clear = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    bit          dbg;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_cpu;
    logic [31:0] exp_dbg;
    bit          exp_wr;
    bit          exp_err;
  } vec_t;

  vec_t vecs [9];

  typedef struct {
    bit          dbg;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  dm_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .dm_addr(dm_addr), .dm_write_data(dm_write_data),
    .ctrl_dataMem_Write(ctrl_dataMem_Write), .ctrl_dataMem2reg(ctrl_dataMem2reg),
    .dm_read_data(dm_read_data), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // Data memory environment: 64 words, combinational read, write on clk.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (ctrl_dataMem_Write === 1'b1) begin
      mem[dm_addr[7:2]] <= dm_write_data;
    end
  end
  assign dm_read_data = mem[dm_addr[7:2]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'd0; dbg_wdata = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; mem_clear = 1'b1; idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0; mem_clear = 1'b0;
  endtask

  task automatic run_single(input vec_t v, input string tag);
    int cyc;
    int wr;
    int wrong_ack;
    bit got;
    logic e;
    cyc = 0; wr = 0; wrong_ack = 0; got = 1'b0; e = 1'b0;
    @(negedge clk);
    if (v.dbg) begin
      dbg_req = 1'b1; dbg_we = v.we; dbg_addr = v.addr; dbg_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    while (!got && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (ctrl_dataMem_Write) wr++;
      if (v.dbg ? cpu_ack : dbg_ack) wrong_ack++;
      if (v.dbg ? dbg_ack : cpu_ack) begin
        got = 1'b1;
        e   = err;
      end
    end
    idle_inputs();
    check({tag, " latency"},   32'(cyc), 32'd2);
    check({tag, " wr_pulses"}, 32'(wr), {31'd0, v.exp_wr});
    check({tag, " err"},       {31'd0, e}, {31'd0, v.exp_err});
    check({tag, " other_ack"}, 32'(wrong_ack), 32'd0);
    check({tag, " cpu_rdata"}, cpu_rdata, v.exp_cpu);
    check({tag, " dbg_rdata"}, dbg_rdata, v.exp_dbg);
  endtask

  initial begin
    logic [31:0] ref_mem [64];
    logic [31:0] ref_cpu, ref_dbg;
    txn_t        cur;
    int          age;
    int          streak;
    int          stray;
    int          n_acks;
    int          both;
    int          cyc;
    bit          take_dbg;
    bit          exp_dbg_grant;

    rst = 1'b1;
    idle_inputs();
    do_reset();

    // Reset state
    check("rst busy",    {31'd0, busy}, 32'd0);
    check("rst cpu_ack", {31'd0, cpu_ack}, 32'd0);
    check("rst dbg_ack", {31'd0, dbg_ack}, 32'd0);
    check("rst err",     {31'd0, err}, 32'd0);
    check("rst ctrl",    {30'd0, ctrl_dataMem_Write, ctrl_dataMem2reg}, 32'd0);
    check("rst rdata",   cpu_rdata | dbg_rdata, 32'd0);

    // Directed single-port transactions; memory word i starts as C0DE_0000|i
    vecs[0] = '{0, 1, 32'h10, 32'hDEADBEEF, 32'h0,        32'h0,        1, 0};
    vecs[1] = '{0, 0, 32'h10, 32'h0,        32'hDEADBEEF, 32'h0,        0, 0};
    vecs[2] = '{1, 0, 32'h20, 32'h0,        32'hDEADBEEF, 32'hC0DE0008, 0, 0};
    vecs[3] = '{1, 1, 32'h24, 32'h12345678, 32'hDEADBEEF, 32'hC0DE0008, 1, 0};
    vecs[4] = '{1, 0, 32'h24, 32'h0,        32'hDEADBEEF, 32'h12345678, 0, 0};
`ifdef DM_ARB_ALIGN_CHECK_EN
    vecs[5] = '{0, 1, 32'h13, 32'hA5A5A5A5, 32'hDEADBEEF, 32'h12345678, 0, 1};
    vecs[6] = '{0, 0, 32'h10, 32'h0,        32'hDEADBEEF, 32'h12345678, 0, 0};
    vecs[7] = '{0, 0, 32'h26, 32'h0,        32'hDEADBEEF, 32'h12345678, 0, 1};
`else
    vecs[5] = '{0, 1, 32'h13, 32'hA5A5A5A5, 32'hDEADBEEF, 32'h12345678, 1, 0};
    vecs[6] = '{0, 0, 32'h10, 32'h0,        32'hA5A5A5A5, 32'h12345678, 0, 0};
    vecs[7] = '{0, 0, 32'h26, 32'h0,        32'h12345678, 32'h12345678, 0, 0};
`endif
    vecs[8] = '{1, 0, 32'hFFFF_FFFC, 32'h0, vecs[7].exp_cpu, 32'hC0DE003F, 0, 0};

    for (int i = 0; i < 9; i++) run_single(vecs[i], $sformatf("vec%0d", i));

    // Reset in the ACCESS cycle of a store aborts it
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h5555AAAA;
    @(negedge clk);
    check("abort access_wr", {31'd0, ctrl_dataMem_Write}, 32'd1);
    rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy",  {31'd0, busy}, 32'd0);
    check("abort ack",   {30'd0, cpu_ack, dbg_ack}, 32'd0);
    check("abort ctrl",  {30'd0, ctrl_dataMem_Write, ctrl_dataMem2reg}, 32'd0);
    check("abort rdata", cpu_rdata, 32'd0);
    stray = 0;
    repeat (4) @(negedge clk) begin
      if (cpu_ack || dbg_ack || err || busy) stray++;
    end
    check("abort stray", 32'(stray), 32'd0);

    // Both ports requesting continuously: LIMIT CPU grants, then one debug
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h4;
    n_acks = 0; both = 0; cyc = 0;
    while (n_acks < 2 * (LIMIT + 1) && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (cpu_ack && dbg_ack) both++;
      if (cpu_ack || dbg_ack) begin
        exp_dbg_grant = ((n_acks % (LIMIT + 1)) == LIMIT);
        check($sformatf("starve grant%0d", n_acks), {31'd0, dbg_ack}, {31'd0, exp_dbg_grant});
        n_acks++;
      end
    end
    check("starve acks",   32'(n_acks), 32'(2 * (LIMIT + 1)));
    check("starve double", 32'(both), 32'd0);
    check("starve dbg_rdata", dbg_rdata, init_word(1));

    // Random traffic against a transaction-level model
    do_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    ref_cpu = 32'd0; ref_dbg = 32'd0; age = 0; streak = 0;
    cur = '{0, 0, 32'd0, 32'd0};
    for (int c = 0; c < 900; c++) begin
      @(negedge clk);
      // age: 0 = no transaction, 1 = memory cycle, 2 = response cycle
      check("rnd busy", {31'd0, busy}, {31'd0, age != 0});
      check("rnd wr",   {31'd0, ctrl_dataMem_Write}, {31'd0, age == 1 && cur.we});
      check("rnd m2r",  {31'd0, ctrl_dataMem2reg}, {31'd0, age == 1 && !cur.we});
      check("rnd addr", dm_addr, (age == 1) ? cur.addr : 32'd0);
      check("rnd wdat", dm_write_data, (age == 1) ? cur.wdata : 32'd0);
      check("rnd acks", {30'd0, cpu_ack, dbg_ack},
            {30'd0, age == 2 && !cur.dbg, age == 2 && cur.dbg});
      check("rnd err",  {31'd0, err}, 32'd0);
      check("rnd cpu_rdata", cpu_rdata, ref_cpu);
      check("rnd dbg_rdata", dbg_rdata, ref_dbg);

      if (cpu_req && cpu_ack) begin
        if ($urandom_range(0, 1) == 0) cpu_req = 1'b0;
        cpu_we = 1'($urandom_range(0, 1)); cpu_addr = $urandom() & 32'hFFFF_FFFC; cpu_wdata = $urandom();
      end else if (!cpu_req && $urandom_range(0, 1) == 0) begin
        cpu_req = 1'b1;
        cpu_we = 1'($urandom_range(0, 1)); cpu_addr = $urandom() & 32'hFFFF_FFFC; cpu_wdata = $urandom();
      end
      if (dbg_req && dbg_ack) begin
        if ($urandom_range(0, 1) == 0) dbg_req = 1'b0;
        dbg_we = 1'($urandom_range(0, 1)); dbg_addr = $urandom() & 32'hFFFF_FFFC; dbg_wdata = $urandom();
      end else if (!dbg_req && $urandom_range(0, 2) == 0) begin
        dbg_req = 1'b1;
        dbg_we = 1'($urandom_range(0, 1)); dbg_addr = $urandom() & 32'hFFFF_FFFC; dbg_wdata = $urandom();
      end

      if (age == 2) begin
        age = 0;
      end else if (age == 1) begin
        age = 2;
        if (cur.we) ref_mem[cur.addr[7:2]] = cur.wdata;
        else if (cur.dbg) ref_dbg = ref_mem[cur.addr[7:2]];
        else ref_cpu = ref_mem[cur.addr[7:2]];
      end else if (cpu_req || dbg_req) begin
        take_dbg = dbg_req && (!cpu_req || streak >= LIMIT);
        if (take_dbg) streak = 0;
        else if (dbg_req) streak = (streak + 1 > LIMIT) ? LIMIT : streak + 1;
        if (take_dbg) cur = '{1, dbg_we, dbg_addr, dbg_wdata};
        else          cur = '{0, cpu_we, cpu_addr, cpu_wdata};
        age = 1;
      end
    end
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
